// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and encoding.
// Optional feature macro used by the top: SERIAL_SUB_OVF_EN (signed overflow output).
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, built from two half subtractors and an OR.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;
    logic na;
    logic nd1;

    // First half subtractor: a - b
    xor g_hs1_d (d1, a, b);
    not g_hs1_n (na, a);
    and g_hs1_b (b1, na, b);

    // Second half subtractor: (a - b) - bin
    xor g_hs2_d (d, d1, bin);
    not g_hs2_n (nd1, d1);
    and g_hs2_b (b2, nd1, bin);

    // A borrow from either stage propagates out
    or  g_bout  (bout, b1, b2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Operands enter through a valid/ready handshake, the result leaves through another.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    // Counter is at least one bit wide so that W=1 still builds
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    diff_q;
    logic [CW-1:0]   cnt_q;
    logic            borrow_q;
    logic            bout_q;
    logic            in_ready_q;
    logic            out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    logic            ovf_q;
`endif

    // Outputs of the single full-subtractor cell working on the operand LSBs
    logic            d_d;
    logic            borrow_d;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (d_d),
        .bout (borrow_d)
    );

    // FSM, counter, shift registers and borrow flip-flop with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    // New difference bit enters at the MSB; after W shifts bit 0 is the LSB
                    diff_q   <= W'({d_d, diff_q} >> 1);
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        bout_q      <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
                        // Signed overflow: borrow into the MSB differs from borrow out of it
                        ovf_q       <= borrow_q ^ borrow_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations,
// expected results queued at issue time and checked by an independent monitor.
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int MAXU = (1 << W);
    localparam int HALF = (1 << (W - 1));

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           a;
        int           b;
        int           bin;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   bp_mode = 0;   // 0: always ready, 1: hold off, 2: random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    function automatic exp_t model(input int av, input int bv, input int bi);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        r      = av - bv - bi;
        e.diff = W'((r + 2 * MAXU) % MAXU);
        e.bout = (av < bv + bi);
        sa     = (av >= HALF) ? av - MAXU : av;
        sb     = (bv >= HALF) ? bv - MAXU : bv;
        r      = sa - sb - bi;
        e.ovf  = (r < -HALF) || (r > HALF - 1);
        e.a    = av;
        e.b    = bv;
        e.bin  = bi;
        return e;
    endfunction

    // Consumer back-pressure, changed just after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every completed output handshake is checked against the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'(diff), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("diff a=%0d b=%0d bin=%0d", e.a, e.b, e.bin), 32'(diff), 32'(e.diff));
                chk($sformatf("bout a=%0d b=%0d bin=%0d", e.a, e.b, e.bin), 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                chk($sformatf("ovf a=%0d b=%0d bin=%0d", e.a, e.b, e.bin), 32'(ovf), 32'(e.ovf));
`endif
                $display("result a=%0d b=%0d bin=%0d -> diff=%0h bout=%0b", e.a, e.b, e.bin, diff, bout);
            end
        end
    end

    // Offer operands, wait for acceptance, optionally queue the expected result,
    // then (if asked) measure latency to out_valid counting the accept edge as clock 1.
    task automatic op(input int av, input int bv, input int bi, input bit push, input bit wait_out);
        int n;
        bit ok;
        @(negedge clk);
        a        = W'(av);
        b        = W'(bv);
        bin      = 1'(bi);
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back(model(av, bv, bi));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_low_after_accept", 32'(in_ready), 32'd0);
        if (!wait_out) return;
        n  = 1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("out_valid_timeout", 32'(out_valid), 32'd1);
        else     chk("latency", 32'(n), 32'(W + 1));
    endtask

    initial begin
        logic [W-1:0] held;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases, consumer always ready
        op(100, 37, 0, 1, 1);
        op(5, 9, 0, 1, 1);
        op(0, 0, 1, 1, 1);
        op(255, 255, 0, 1, 1);
        op(8'h80, 8'h01, 0, 1, 1);
        op(8'h10, 8'h01, 0, 1, 1);

        // Hold the result in DONE while new operands are offered
        @(negedge clk);
        bp_mode = 1;
        @(negedge clk);
        op(200, 13, 1, 1, 1);
        @(negedge clk);
        held     = diff;
        a        = W'(50);
        b        = W'(60);
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_diff", 32'(diff), 32'(held));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        bp_mode = 0;
        op(50, 60, 0, 1, 1);

        // Reset on the 3rd SHIFT cycle discards the operation
        op(20, 7, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        op(20, 7, 0, 1, 1);

        // Random operands under random back-pressure
        bp_mode = 2;
        for (int k = 0; k < 30; k++) begin
            op(int'($urandom_range(0, MAXU - 1)), int'($urandom_range(0, MAXU - 1)),
               int'($urandom_range(0, 1)), 1, 1);
        end
        bp_mode = 0;

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
